// File: rtl/noise_shaper.sv
// Noise voice: sample-and-hold decimation, one-pole lowpass and a linear
// attack/release gain ramp on a free-running white-noise stream.
module noise_shaper #(
  parameter int RAMP_BITS = 8,
  parameter int FRAC_BITS = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_data,
  input  logic [15:0] i_rate,
  input  logic [3:0]  i_shift,
  input  logic        i_gate,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_busy
);
  localparam int AW = 16 + FRAC_BITS;
  localparam int GW = RAMP_BITS + 1;
  localparam int PW = 16 + GW + 1;
  localparam logic [GW-1:0] GMAX = {1'b1, {RAMP_BITS{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ATK,
    S_SUS,
    S_REL
  } state_t;

  logic        [15:0]   r_cnt;
  logic signed [15:0]   r_hold;
  logic signed [AW-1:0] r_acc;
  logic        [GW-1:0] r_gain;
  state_t               r_state;
  logic                 r_t1;
  logic                 r_t2;

  logic        [15:0]   w_rate_m1;
  logic                 w_tick;
  logic signed [AW-1:0] w_target;
  logic signed [AW:0]   w_diff;
  logic signed [AW:0]   w_step;
  logic signed [AW:0]   w_sum;
  logic signed [AW-1:0] w_acc_nx;
  logic signed [15:0]   w_y;
  logic signed [PW-1:0] w_ya;
  logic signed [PW-1:0] w_ga;
  logic signed [PW-1:0] w_prod;
  logic        [15:0]   w_res;
  logic                 w_unused;

  assign w_rate_m1 = (i_rate == 16'd0) ? 16'd0 : i_rate - 16'd1;
  assign w_tick    = (r_cnt >= w_rate_m1);

  // Filter math is done one bit wider so the difference never wraps.
  assign w_target = {r_hold, {FRAC_BITS{1'b0}}};
  assign w_diff   = {w_target[AW-1], w_target} - {r_acc[AW-1], r_acc};
  assign w_step   = w_diff >>> i_shift;
  assign w_sum    = {r_acc[AW-1], r_acc} + w_step;
  assign w_acc_nx = (i_shift == 4'd0) ? w_target : w_sum[AW-1:0];

  assign w_y    = r_acc[AW-1:FRAC_BITS];
  assign w_ya   = PW'(w_y);
  assign w_ga   = PW'({1'b0, r_gain});
  assign w_prod = w_ya * w_ga;
  assign w_res  = w_prod[RAMP_BITS +: 16];

  assign w_unused = ^{w_sum[AW], w_prod[PW-1:RAMP_BITS+16],
                      w_prod[RAMP_BITS-1:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_hold <= '0;
      r_t1 <= 1'b0;
    end else begin
      r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
      r_t1 <= w_tick;
      if (w_tick) r_hold <= i_data;
    end
  end

  // Envelope advances only on ticks; gate is sampled there too.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_gain <= '0;
    end else if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          r_gain <= '0;
          if (i_gate) r_state <= S_ATK;
        end
        S_ATK: begin
          if (!i_gate) begin
            r_state <= S_REL;
          end else if (r_gain == GMAX) begin
            r_state <= S_SUS;
          end else begin
            r_gain <= r_gain + GW'(1);
            if (r_gain == GMAX - GW'(1)) r_state <= S_SUS;
          end
        end
        S_SUS: begin
          if (!i_gate) r_state <= S_REL;
        end
        S_REL: begin
          if (i_gate) begin
            r_state <= S_ATK;
          end else if (r_gain == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_gain <= r_gain - GW'(1);
            if (r_gain == GW'(1)) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc <= '0;
      r_t2 <= 1'b0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      r_t2 <= r_t1;
      if (r_t1) r_acc <= w_acc_nx;
      o_valid <= r_t2;
      if (r_t2) o_data <= (w_res == 16'h8000) ? 16'h8001 : w_res;
      o_busy <= (r_state != S_IDLE);
    end
  end
endmodule

// File: tb/tb_noise_shaper.sv
// Directed and randomized checks of noise_shaper against an
// integer reference model of the sample/filter/envelope chain.
module tb_noise_shaper;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [15:0] rate = 16'd1;
  logic [3:0]  shift = '0;
  logic        gate = 1'b0;
  logic [15:0] odata;
  logic        ovalid;
  logic        obusy;

  int checks = 0;
  int errors = 0;

  // reference model state (plain integers)
  int m_cnt, m_hold, m_acc, m_gain, m_st, m_t1, m_t2;
  int e_data, e_valid, e_busy;

  always #5 clk = ~clk;

  noise_shaper #(.RAMP_BITS(8), .FRAC_BITS(8)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (data),
    .i_rate (rate),
    .i_shift(shift),
    .i_gate (gate),
    .o_data (odata),
    .o_valid(ovalid),
    .o_busy (obusy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_hold = 0; m_acc = 0; m_gain = 0; m_st = 0;
    m_t1 = 0; m_t2 = 0;
    e_data = 0; e_valid = 0; e_busy = 0;
  endfunction

  // One clock edge of the reference: outputs from pre-edge values,
  // then filter, then sample/envelope on a tick.
  function automatic void model_edge();
    int reff, p;
    bit tick;
    reff = (rate == 0) ? 1 : int'(rate);
    tick = (m_cnt >= reff - 1);
    e_valid = m_t2;
    if (m_t2 != 0) begin
      p = ((m_acc >>> 8) * m_gain) >>> 8;
      e_data = (p == -32768) ? -32767 : p;
    end
    e_busy = (m_st != 0);
    if (m_t1 != 0) begin
      if (shift == 0) m_acc = m_hold * 256;
      else m_acc = m_acc + ((m_hold * 256 - m_acc) >>> shift);
    end
    m_t2 = m_t1;
    m_t1 = tick;
    if (tick) begin
      m_cnt = 0;
      m_hold = int'($signed(data));
      if (m_st == 0) begin
        m_gain = 0;
        if (gate) m_st = 1;
      end else if (m_st == 1) begin
        if (!gate) m_st = 3;
        else if (m_gain >= 256) m_st = 2;
        else begin
          m_gain++;
          if (m_gain == 256) m_st = 2;
        end
      end else if (m_st == 2) begin
        if (!gate) m_st = 3;
      end else begin
        if (gate) m_st = 1;
        else if (m_gain == 0) m_st = 0;
        else begin
          m_gain--;
          if (m_gain == 0) m_st = 0;
        end
      end
    end else begin
      m_cnt++;
    end
  endfunction

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("valid", int'(ovalid), e_valid);
    chk("busy", int'(obusy), e_busy);
    chk("data", int'($signed(odata)), e_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nv, first, seen, cnt;
    int t3_exp[4];
    t3_exp = '{1000, 1750, 2312, 2734};

    #2;
    chk("rst_data", int'(odata), 0);
    chk("rst_valid", int'(ovalid), 0);
    chk("rst_busy", int'(obusy), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // T1: ramp at rate 1
    rate = 16'd1; shift = 4'd0; data = 16'd1000; gate = 1'b1;
    nv = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (ovalid) begin
        nv++;
        if (nv <= 3) chk("t1_ramp", int'($signed(odata)), 4 * nv - 1);
        if (nv >= 256) chk("t1_full", int'($signed(odata)), 1000);
      end
    end

    // T5: negative full scale, rate 0
    rate = 16'd0; data = 16'h8000;
    for (int i = 0; i < 6; i++) cyc();
    chk("t5_sat", int'($signed(odata)), -32767);
    chk("t5_valid", int'(ovalid), 1);

    // T3: lowpass step response
    rate = 16'd1; data = 16'd0;
    for (int i = 0; i < 5; i++) cyc();
    data = 16'd4000; shift = 4'd2;
    seen = 0;
    for (int i = 0; i < 20 && seen < 4; i++) begin
      cyc();
      if (ovalid && odata != 16'd0) begin
        chk("t3_step", int'($signed(odata)), t3_exp[seen]);
        seen++;
      end
    end
    chk("t3_count", seen, 4);

    // T2: decimation by 4, data = cycle index
    shift = 4'd0; rate = 16'd4;
    for (int i = 0; i < 40; i++) begin
      data = 16'(i);
      cyc();
    end

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      data = 16'($urandom);
      if (i % 64 == 0) rate = 16'($urandom_range(0, 5));
      if (i % 37 == 0) shift = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) gate = ~gate;
      cyc();
    end

    // T4: 100 ticks of gate, then release to idle
    do_reset();
    rate = 16'd1; shift = 4'd0; data = 16'd5000; gate = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    gate = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cyc();
      cnt++;
      if (!obusy) break;
    end
    chk("t4_busy_fall", int'(obusy), 0);
    chk("t4_fall_cycles", cnt, 101);

    // T6: async reset mid-release
    gate = 1'b1;
    for (int i = 0; i < 100; i++) cyc();
    gate = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    chk("t6_pre_busy", int'(obusy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_data", int'(odata), 0);
    chk("t6_valid", int'(ovalid), 0);
    chk("t6_busy", int'(obusy), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rate = 16'd3;
    first = -1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (ovalid && first < 0) first = i;
    end
    chk("t6_first_valid", first, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
